// File: rtl/dual_switch_debounce.sv
// rtl/dual_switch_debounce.sv - two-channel switch synchronizer and debouncer with XOR and edge pulses
//
// Purpose: brings two raw, bouncy slide-switch lines into the clk domain,
// debounces each channel independently and presents clean levels, their XOR
// and optional one-cycle rise/fall pulses to downstream logic.
//
// Parameters:
//   STABLE_CYCLES - consecutive synchronized samples that must differ from the
//                   debounced level before it updates (2 .. 2^CNT_W-1)
//   CNT_W         - width of each per-channel stability counter
//
// Ports:
//   clk      in  sole clock, rising edge
//   rst      in  synchronous active-high reset
//   sw_a_raw in  raw switch A (asynchronous)
//   sw_b_raw in  raw switch B (asynchronous)
//   a, b     out debounced levels (registered)
//   f        out a ^ b (combinational from registered levels)
//   a_rise, a_fall, b_rise, b_fall
//            out one-cycle pulses aligned with the new level (registered)
//
// Build option: DUAL_SWITCH_DEBOUNCE_EDGE_EN compiles in the pulse registers;
// without it the four pulse outputs are constant 0.

module dual_switch_debounce #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_a_raw,
    input  logic sw_b_raw,
    output logic a,
    output logic b,
    output logic f,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit 0 is channel A, bit 1 is channel B throughout.
    logic [1:0]            raw;
    logic [1:0]            s1_q;
    logic [1:0]            s2_q;
    logic [1:0]            level_q;
    logic [1:0]            level_d;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [1:0]            commit;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;

    assign raw = {sw_b_raw, sw_a_raw};

    // State register: synchronizers, FSM state, counters and levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= {2{ST_STABLE}};
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Next-state logic. The counter holds the number of consecutive samples
    // that disagreed with the level; it is cleared before it could reach
    // STABLE_CYCLES, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = '0;
        for (int c = 0; c < 2; c++) begin
            if (state_q[c] == ST_STABLE) begin
                if (s2_q[c] != level_q[c]) begin
                    state_d[c] = ST_PENDING;
                    cnt_d[c]   = CNT_ONE;
                end
            end else begin
                if (s2_q[c] == level_q[c]) begin
                    // Bounced back before qualifying: forget the partial run.
                    state_d[c] = ST_STABLE;
                    cnt_d[c]   = '0;
                end else if (cnt_q[c] == CNT_LAST) begin
                    state_d[c] = ST_STABLE;
                    cnt_d[c]   = '0;
                    commit[c]  = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_ONE;
                end
            end
        end
    end

    // Output logic. A commit only happens while s2 disagrees with the level,
    // so accepting the new value is a simple toggle.
    always_comb begin
        level_d = level_q ^ commit;
    end

    assign a = level_q[0];
    assign b = level_q[1];
    assign f = level_q[0] ^ level_q[1];

`ifdef DUAL_SWITCH_DEBOUNCE_EDGE_EN
    logic [1:0] rise_d;
    logic [1:0] fall_d;
    logic [1:0] rise_q;
    logic [1:0] fall_q;

    always_comb begin
        rise_d = commit & s2_q;
        fall_d = commit & ~s2_q;
    end

    // Registered alongside the level so each pulse lines up with the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign a_rise = rise_q[0];
    assign a_fall = fall_q[0];
    assign b_rise = rise_q[1];
    assign b_fall = fall_q[1];
`else
    assign a_rise = 1'b0;
    assign a_fall = 1'b0;
    assign b_rise = 1'b0;
    assign b_fall = 1'b0;
`endif

endmodule

// File: tb/tb_dual_switch_debounce.sv
// tb/tb_dual_switch_debounce.sv - self-checking bench for dual_switch_debounce

module tb_dual_switch_debounce;

    localparam int S = 4;
`ifdef DUAL_SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sw_a_raw;
    logic sw_b_raw;
    logic a, b, f, a_rise, a_fall, b_rise, b_fall;

    int total = 0;
    int bad   = 0;

    dual_switch_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_a_raw(sw_a_raw),
        .sw_b_raw(sw_b_raw),
        .a       (a),
        .b       (b),
        .f       (f),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall)
    );

    always #5 clk = ~clk;

    // Reference model: a channel's level flips at an edge when the last S
    // synchronized samples since reset all disagree with it. The synchronized
    // sample seen at edge t is the raw value captured at edge t-2.
    int       m_n;
    bit       m_raw [2][64];
    bit [1:0] m_lvl;
    bit [1:0] m_rise;
    bit [1:0] m_fall;

    function automatic bit s2_at(input int c, input int t);
        return (t >= 2) ? m_raw[c][(t - 2) % 64] : 1'b0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_n    = 0;
            m_lvl  = '0;
            m_rise = '0;
            m_fall = '0;
        end else begin
            m_raw[0][m_n % 64] = sw_a_raw;
            m_raw[1][m_n % 64] = sw_b_raw;
            for (int c = 0; c < 2; c++) begin
                bit all_diff;
                all_diff = (m_n >= S - 1);
                for (int t = m_n - S + 1; t <= m_n; t++)
                    if (t >= 0 && s2_at(c, t) == m_lvl[c]) all_diff = 1'b0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (all_diff) begin
                    m_lvl[c]  = ~m_lvl[c];
                    m_rise[c] = m_lvl[c];
                    m_fall[c] = ~m_lvl[c];
                end
            end
            m_n++;
        end
    endtask

    function automatic logic [6:0] ev(input bit ea, input bit eb, input bit ear,
                                      input bit eaf, input bit ebr, input bit ebf);
        return {ea, eb, ea ^ eb, ear & EDGE, eaf & EDGE, ebr & EDGE, ebf & EDGE};
    endfunction

    function automatic logic [6:0] model_vec();
        return ev(m_lvl[0], m_lvl[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]);
    endfunction

    function automatic logic [6:0] got_vec();
        return {a, b, f, a_rise, a_fall, b_rise, b_fall};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = got_vec();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got {a,b,f,ar,af,br,bf}=%b expected=%b", name, $time, got, exp);
        end
    endtask

    // Apply inputs for one edge, advance the model, then sample after the edge.
    task automatic step(input logic r, input logic ra, input logic rb);
        rst      = r;
        sw_a_raw = ra;
        sw_b_raw = rb;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic       ra;
        logic       rb;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic ra, input logic rb, input logic [6:0] e);
        vec_t v;
        v.r   = r;
        v.ra  = ra;
        v.rb  = rb;
        v.exp = e;
        return v;
    endfunction

    initial begin
        int hold_a;
        int hold_b;
        logic ra;
        logic rb;

        rst      = 1'b1;
        sw_a_raw = 1'b1;
        sw_b_raw = 1'b1;
        m_n      = 0;
        m_lvl    = '0;
        m_rise   = '0;
        m_fall   = '0;

        // Reset held with both switches high, then release: both rise 6 edges later.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 1'b1, 1'b1, ev(0, 0, 0, 0, 0, 0)));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(1'b0, 1'b1, 1'b1, ev(i >= 6, i >= 6, i == 6, 0, i == 6, 0)));
        // A falls while B stays high.
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, ev(i < 6, 1, 0, i == 6, 0, 0)));
        // B falls.
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b0, ev(0, i < 6, 0, 0, 0, i == 6)));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].ra, tbl[i].rb);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Short glitches are rejected.
        step(1'b0, 1'b1, 1'b0); check("bounce", ev(0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0, 1'b0); check("bounce", ev(0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b1, 1'b0); check("bounce", ev(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("bounce_settle", ev(0, 0, 0, 0, 0, 0));
        end
        // Clean step on A: level and rise pulse at the 6th edge, f follows.
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("a_step", ev(i >= 6, 0, i == 6, 0, 0, 0));
        end

        step(1'b1, 1'b0, 1'b0);
        check("reset_clear", ev(0, 0, 0, 0, 0, 0));

        // Simultaneous rise: both update on the same edge, f stays 0.
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("simultaneous", ev(i >= 6, i >= 6, i == 6, 0, i == 6, 0));
        end

        step(1'b1, 1'b0, 1'b0);
        check("reset_clear2", ev(0, 0, 0, 0, 0, 0));

        // Reset while B is mid-count discards the partial run.
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check("b_pre_reset", ev(0, 0, 0, 0, 0, 0));
        end
        step(1'b1, 1'b0, 1'b1);
        check("b_reset_mid", ev(0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check("b_after_reset", ev(0, i >= 6, 0, 0, i == 6, 0));
        end

        // Randomized holds of 1..10 cycles with occasional resets, against the model.
        step(1'b1, 1'b0, 1'b0);
        check("rand_reset", model_vec());
        hold_a = 0;
        hold_b = 0;
        ra     = 1'b0;
        rb     = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_a == 0) begin
                ra     = ~ra;
                hold_a = $urandom_range(1, 10);
            end
            if (hold_b == 0) begin
                rb     = ~rb;
                hold_b = $urandom_range(1, 10);
            end
            hold_a--;
            hold_b--;
            step(($urandom_range(0, 199) == 0), ra, rb);
            check("random", model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
